// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with frame-atomic display update
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_FIRST = NUM_DIGITS'(1);
    localparam logic                  INV      = (ACTIVE_LOW != 0);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] stage_data;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;

    // Seven-segment glyph lookup; values above 9 show a dash unless hex glyphs are enabled.
    function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        if (!hex && (v > 4'h9)) begin
            g = 7'h40;
        end
        return g;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Slot prescaler and digit index; the index wrap is the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Staging takes every load; the display only changes at a frame boundary so a frame never mixes values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_data <= '0;
            stage_dp   <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap && pending) begin
                disp_data <= stage_data;
                disp_dp   <= stage_dp;
            end
            if (load) begin
                stage_data <= data_in;
                stage_dp   <= dp_in;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero detection: upper_zero[i] is set when digits i..top are all zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run && (disp_data[4*i +: 4] == 4'h0);
            upper_zero[i] = run;
        end
        cur_digit = disp_data[{idx, 2'b00} +: 4];
        cur_blank = blank_lz && (idx != '0) && upper_zero[idx];
    end

    // Pin registers: seg, dp and an follow the index one clock later, all together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'h3F;
            dp_r  <= 1'b0;
            an_r  <= AN_FIRST;
        end else begin
            seg_r <= cur_blank ? 7'h00 : glyph(cur_digit, hex_mode);
            dp_r  <= disp_dp[idx];
            an_r  <= AN_FIRST << idx;
        end
    end

    assign seg = seg_r ^ {7{INV}};
    assign dp  = dp_r ^ INV;
    assign an  = an_r ^ {NUM_DIGITS{INV}};

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- SCAN_DIV, 50000, clocks per digit slot; legal range >=1, where 1 means one slot per clock.
- ACTIVE_LOW, 0, 1 inverts seg, dp and an at the pins.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  4*NUM_DIGITS  digit i at [4i+3:4i]; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- load  input  1  capture data_in/dp_in this edge.
- hex_mode  input  1  1: show A-F glyphs; 0: values 10-15 show dash.
- blank_lz  input  1  leading-zero blanking enable.
- seg  output  7  bit0=a ... bit6=g.
- dp  output  1  decimal point of the active digit.
- an  output  NUM_DIGITS  one-hot digit select.
- frame_done  output  1  one-clock pulse per completed scan frame.
- pending  output  1  staged value not yet displayed.

Function
REQ-003 The prescaler SHALL count 0..SCAN_DIV-1, assert tick when count==SCAN_DIV-1, and wrap to 0 on the same edge.
REQ-004 On tick, the digit index SHALL increment, wrapping from NUM_DIGITS-1 to 0; with NUM_DIGITS=1 the index SHALL stay at 0 and every tick SHALL be a frame boundary.
REQ-005 When load=1 at an edge, the staging register SHALL capture data_in and dp_in and set pending=1; the last load before the frame boundary wins.
REQ-006 At the edge where the index wraps to 0:
- if pending=1, the display register SHALL take the staging contents and pending SHALL clear, so no frame ever mixes old and new digits;
- frame_done SHALL pulse high for exactly the following cycle.
REQ-007 If load coincides with the commit edge, the display register SHALL take the pre-edge staging value, staging SHALL take the new data, and pending SHALL remain 1.
REQ-008 seg, dp and an SHALL be registered and change together, one clock after the edge that updates the index.
REQ-009 The glyph table (pre-polarity, hex) SHALL be:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F;
- A=77, b=7C, C=39, d=5E, E=79, F=71;
- when hex_mode=0, values 10-15 SHALL show dash 40.
REQ-010 With blank_lz=1, digit i (i>0) SHALL drive seg=00 when digits i..NUM_DIGITS-1 of the display register are all zero; digit 0 SHALL never be blanked, and dp SHALL be unaffected by blanking.
REQ-011 an SHALL be one-hot at bit index (pre-polarity); ACTIVE_LOW=1 SHALL bitwise-invert seg, dp and an, and no other output.
REQ-012 hex_mode and blank_lz SHALL be sampled live each slot and are not staged.

Reset
REQ-013 While rst_n=0, independent of clk: prescaler=0, index=0, staging=0, display=0, pending=0, frame_done=0, an=bit0 selected, seg=3F, dp=0 (pre-polarity).
REQ-014 Counting SHALL resume on the first clk edge after rst_n rises; an in-flight pending value SHALL be discarded.

Verification (NUM_DIGITS=4, SCAN_DIV=4 unless stated)
REQ-015 Reset release, blank_lz=0, no load -> an steps 0001,0010,0100,1000 every 4 clocks, seg=3F throughout, frame_done pulses every 16 clocks.
REQ-016 load 16'h12AF, hex_mode=1 -> pending=1 until the next frame boundary, then digits 0..3 show 71,77,5B,06; with hex_mode=0, digits 0 and 1 show 40.
REQ-017 load 16'h0050, blank_lz=1 -> digits 3,2 show 00, digit 1 shows 6D, digit 0 shows 3F; load 16'h0000 -> only digit 0 lit, showing 3F.
REQ-018 load 16'h1111 then 16'h2222 within one frame -> glyph 06 never appears, 5B appears on all digits from the next frame; load on the commit edge -> REQ-007 behaviour.
REQ-019 rst_n dropped mid-slot with pending=1 -> outputs reach REQ-013 values with no clk edge, and pending=0 after release.
REQ-020 ACTIVE_LOW=1, load 16'h8888 -> seg=00 after commit, an=1110 for digit 0, dp=1 while dp_in=0.
